// File: rtl/alu_seq_pkg.sv
// Shared definitions for the ALU operand sequencer and the ALU itself.
//   state_t         : sequencer FSM state encoding
//   OP_*            : opcodes implemented by the ALU
//   is_legal_opcode : 1 when the ALU implements the given opcode
package alu_seq_pkg;

  typedef enum logic [1:0] {
    WAIT_OP1    = 2'd0,
    WAIT_OP2    = 2'd1,
    WAIT_OPCODE = 2'd2,
    SHOW_RESULT = 2'd3
  } state_t;

  localparam logic [3:0] OP_ADD = 4'b0000;
  localparam logic [3:0] OP_SUB = 4'b0100;
  localparam logic [3:0] OP_AND = 4'b0010;
  localparam logic [3:0] OP_OR  = 4'b0101;
  localparam logic [3:0] OP_MUL = 4'b0001;

  function automatic logic is_legal_opcode(input logic [3:0] code);
    case (code)
      OP_ADD, OP_SUB, OP_AND, OP_OR, OP_MUL: return 1'b1;
      default:                               return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/rise_detect.sv
// One-cycle rising-edge detector for a debounced button level.
//   clk, reset : clock and synchronous active-high reset
//   level      : debounced button level
//   rise       : high for the single cycle where level is 1 and was 0 before
// The history flop resets to 1 so a button held through reset is not seen
// as a fresh press.
module rise_detect (
  input  logic clk,
  input  logic reset,
  input  logic level,
  output logic rise
);

  logic level_q;

  always_ff @(posedge clk) begin
    if (reset) level_q <= 1'b1;
    else       level_q <= level;
  end

  assign rise = level & ~level_q;

endmodule

// File: rtl/alu_operand_sequencer.sv
// Front end for the N-bit ALU: collects op1, op2 and opcode from the switch
// bank on successive Enter presses, steps back one entry on Undo, and picks
// what the 7-segment driver shows.
//   clk, reset    : clock and synchronous active-high reset
//   data_in       : live switch value
//   enter, undo   : debounced button levels
//   alu_result    : combinational ALU result for op1/op2/opcode
//   op1, op2      : registered operands to the ALU
//   opcode        : registered opcode to the ALU
//   display_value : data_in while collecting, alu_result when showing result
//   state_leds    : one-hot state (bit0 WAIT_OP1 .. bit3 SHOW_RESULT)
//   result_valid  : high in SHOW_RESULT
//   err           : last opcode entry was illegal
module alu_operand_sequencer
  import alu_seq_pkg::*;
#(
  parameter int N = 16
) (
  input  logic         clk,
  input  logic         reset,
  input  logic [N-1:0] data_in,
  input  logic         enter,
  input  logic         undo,
  input  logic [N-1:0] alu_result,
  output logic [N-1:0] op1,
  output logic [N-1:0] op2,
  output logic [3:0]   opcode,
  output logic [N-1:0] display_value,
  output logic [3:0]   state_leds,
  output logic         result_valid,
  output logic         err
);

  state_t       state, state_nxt;
  logic [N-1:0] op1_nxt, op2_nxt;
  logic [3:0]   opcode_nxt;
  logic         err_nxt;
  logic         enter_rise, undo_rise;

  rise_detect u_enter_rise (.clk(clk), .reset(reset), .level(enter), .rise(enter_rise));
  rise_detect u_undo_rise  (.clk(clk), .reset(reset), .level(undo),  .rise(undo_rise));

  always_ff @(posedge clk) begin
    if (reset) begin
      state  <= WAIT_OP1;
      op1    <= '0;
      op2    <= '0;
      opcode <= OP_ADD;
      err    <= 1'b0;
    end else begin
      state  <= state_nxt;
      op1    <= op1_nxt;
      op2    <= op2_nxt;
      opcode <= opcode_nxt;
      err    <= err_nxt;
    end
  end

  // Simultaneous Enter and Undo edges cancel each other out.
  always_comb begin
    state_nxt  = state;
    op1_nxt    = op1;
    op2_nxt    = op2;
    opcode_nxt = opcode;
    err_nxt    = err;
    if (enter_rise && !undo_rise) begin
      case (state)
        WAIT_OP1: begin
          op1_nxt   = data_in;
          state_nxt = WAIT_OP2;
        end
        WAIT_OP2: begin
          op2_nxt   = data_in;
          state_nxt = WAIT_OPCODE;
        end
        WAIT_OPCODE: begin
          if (is_legal_opcode(data_in[3:0])) begin
            opcode_nxt = data_in[3:0];
            err_nxt    = 1'b0;
            state_nxt  = SHOW_RESULT;
          end else begin
            err_nxt = 1'b1;
          end
        end
        SHOW_RESULT: begin
          op1_nxt    = '0;
          op2_nxt    = '0;
          opcode_nxt = OP_ADD;
          state_nxt  = WAIT_OP1;
        end
        default: state_nxt = WAIT_OP1;
      endcase
    end else if (undo_rise && !enter_rise) begin
      // Undo only moves the state back; stored values stay until re-entered.
      case (state)
        WAIT_OP2:    begin state_nxt = WAIT_OP1;    err_nxt = 1'b0; end
        WAIT_OPCODE: begin state_nxt = WAIT_OP2;    err_nxt = 1'b0; end
        SHOW_RESULT: begin state_nxt = WAIT_OPCODE; err_nxt = 1'b0; end
        default:     state_nxt = state;
      endcase
    end
  end

  assign state_leds    = 4'b0001 << state;
  assign result_valid  = (state == SHOW_RESULT);
  assign display_value = (state == SHOW_RESULT) ? alu_result : data_in;

endmodule

// File: tb/tb_alu_operand_sequencer.sv
// Directed plus randomized bench for alu_operand_sequencer with a small
// entry-count reference model and a behavioural ALU.
module tb_alu_operand_sequencer;

  logic        clk = 1'b0;
  logic        reset;
  logic [15:0] data_in;
  logic        enter, undo;
  logic [15:0] alu_result;
  logic [15:0] op1, op2;
  logic [3:0]  opcode;
  logic [15:0] display_value;
  logic [3:0]  state_leds;
  logic        result_valid, err;

  int total = 0;
  int bad   = 0;

  // reference model: number of values accepted so far (0..3) plus stored values
  int          m_idx;
  logic [15:0] m_op1, m_op2;
  logic [3:0]  m_opc;
  logic        m_err;

  alu_operand_sequencer #(.N(16)) dut (
    .clk(clk), .reset(reset), .data_in(data_in), .enter(enter), .undo(undo),
    .alu_result(alu_result), .op1(op1), .op2(op2), .opcode(opcode),
    .display_value(display_value), .state_leds(state_leds),
    .result_valid(result_valid), .err(err)
  );

  always #5 clk = ~clk;

  function automatic logic [15:0] alu_f(input logic [15:0] a, b, input logic [3:0] op);
    logic [31:0] p;
    p = a * b;
    case (op)
      4'b0000: return a + b;
      4'b0100: return a - b;
      4'b0010: return a & b;
      4'b0101: return a | b;
      4'b0001: return p[15:0];
      default: return 16'h0000;
    endcase
  endfunction

  always_comb alu_result = alu_f(op1, op2, opcode);

  function automatic logic legal(input logic [3:0] c);
    logic [3:0] codes [5] = '{4'h0, 4'h4, 4'h2, 4'h5, 4'h1};
    foreach (codes[i]) if (codes[i] == c) return 1'b1;
    return 1'b0;
  endfunction

  task automatic m_reset();
    m_idx = 0; m_op1 = 0; m_op2 = 0; m_opc = 0; m_err = 0;
  endtask

  task automatic m_enter(input logic [15:0] d);
    if (m_idx == 0)      begin m_op1 = d; m_idx = 1; end
    else if (m_idx == 1) begin m_op2 = d; m_idx = 2; end
    else if (m_idx == 2) begin
      if (legal(d[3:0])) begin m_opc = d[3:0]; m_err = 0; m_idx = 3; end
      else m_err = 1;
    end else begin m_op1 = 0; m_op2 = 0; m_opc = 0; m_idx = 0; end
  endtask

  task automatic m_undo();
    if (m_idx > 0) begin m_idx = m_idx - 1; m_err = 0; end
  endtask

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string tag);
    chk({tag, ".op1"},    32'(op1),          32'(m_op1));
    chk({tag, ".op2"},    32'(op2),          32'(m_op2));
    chk({tag, ".opcode"}, 32'(opcode),       32'(m_opc));
    chk({tag, ".leds"},   32'(state_leds),   32'(1 << m_idx));
    chk({tag, ".rvalid"}, 32'(result_valid), 32'(m_idx == 3));
    chk({tag, ".err"},    32'(err),          32'(m_err));
    chk({tag, ".disp"},   32'(display_value),
        32'((m_idx == 3) ? alu_f(m_op1, m_op2, m_opc) : data_in));
  endtask

  task automatic press(input logic e, input logic u, input logic [15:0] d);
    data_in = d; enter = e; undo = u;
    tick();
    enter = 0; undo = 0;
    tick();
    if (e && !u) m_enter(d);
    else if (u && !e) m_undo();
  endtask

  initial begin
    logic [15:0] d;
    logic [3:0]  legal_codes [5] = '{4'h0, 4'h4, 4'h2, 4'h5, 4'h1};
    int          r;

    // reset
    reset = 1; enter = 0; undo = 0; data_in = 16'h1234;
    repeat (3) tick();
    reset = 0; tick();
    m_reset();
    check_all("reset");

    // basic add
    press(1, 0, 16'h0005); check_all("add_op1");
    press(1, 0, 16'h0003); check_all("add_op2");
    press(1, 0, 16'h0000); check_all("add_opc");
    chk("add_disp_const", 32'(display_value), 32'h0008);
    press(1, 0, 16'h00AA); check_all("add_back");

    // illegal opcode then mul
    press(1, 0, 16'($urandom)); press(1, 0, 16'($urandom));
    press(1, 0, 16'h000F); check_all("illegal");
    chk("illegal_err_const", 32'(err), 32'd1);
    press(1, 0, 16'h0001); check_all("mul");

    // back to WAIT_OP1, then hold enter 20 cycles
    press(1, 0, 16'h0000); check_all("to_op1");
    d = 16'($urandom);
    data_in = d; enter = 1;
    repeat (20) tick();
    enter = 0; tick();
    m_enter(d); check_all("held");

    // simultaneous edges
    press(1, 1, 16'($urandom)); check_all("simul");

    // to SHOW_RESULT then undo x4
    press(1, 0, 16'($urandom));
    press(1, 0, {12'h0, legal_codes[$urandom_range(0, 4)]}); check_all("undo_pre");
    for (int i = 0; i < 4; i++) begin
      press(0, 1, 16'($urandom)); check_all($sformatf("undo%0d", i));
    end

    // reset mid-sequence with enter rising in the same cycle
    press(1, 0, 16'($urandom)); press(1, 0, 16'($urandom)); check_all("pre_rst");
    data_in = 16'h0004; enter = 1; reset = 1;
    tick();
    m_reset(); check_all("rst_mid");
    reset = 0;
    repeat (3) tick();
    check_all("rst_held_enter");
    enter = 0; tick();
    press(1, 0, 16'($urandom)); check_all("rst_after");

    // random walk
    for (int i = 0; i < 60; i++) begin
      r = $urandom_range(0, 9);
      d = 16'($urandom);
      if (m_idx == 2 && $urandom_range(0, 1) == 1) d[3:0] = legal_codes[$urandom_range(0, 4)];
      if (r < 5)      press(1, 0, d);
      else if (r < 9) press(0, 1, d);
      else            press(1, 1, d);
      check_all($sformatf("rnd%0d", i));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
